// File: rtl/rcs_pkg.sv
// Shared helpers for the pipelined ripple-borrow subtractor: stage count and per-stage control record.
package rcs_pkg;

    function automatic int rcs_stages(input int n, input int chunk);
        return (n + chunk - 1) / chunk;
    endfunction

    typedef struct packed {
        logic valid;
        logic borrow;
    } stage_ctl_t;

endpackage

// File: rtl/rcs_chunk.sv
// Combinational W-bit ripple-borrow slice: {bo, diff} = x - y - bi.
module rcs_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] diff,
    output logic         bo
);

    logic [W:0] br;

    assign br[0] = bi;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign diff[gi]  = x[gi] ^ y[gi] ^ br[gi];
        // borrow when x<y, or when x==y and a borrow is already pending
        assign br[gi+1]  = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & br[gi]);
    end

    assign bo = br[W];

endmodule

// File: rtl/rcs_pipe_sub.sv
// Pipelined subtractor d = a - b - bin, one CHUNK-bit slice resolved per stage, valid/ready both sides.
// Optional SUB_CMP_EN macro adds registered compare outputs eq, lt_u, lt_s.
module rcs_pipe_sub
    import rcs_pkg::*;
#(
    parameter int N     = 34,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
`ifdef SUB_CMP_EN
    output logic         eq,
    output logic         lt_u,
    output logic         lt_s,
`endif
    output logic         ovf
);

    localparam int STAGES = rcs_stages(N, CHUNK);
    localparam int LAST_W = N - (STAGES - 1) * CHUNK;

    stage_ctl_t   ctl_src [STAGES];
    stage_ctl_t   ctl_reg [STAGES];
    logic [N-1:0] a_src   [STAGES];
    logic [N-1:0] b_src   [STAGES];
    logic [N-1:0] d_src   [STAGES];
    logic [N-1:0] a_reg   [STAGES];
    logic [N-1:0] b_reg   [STAGES];
    logic [N-1:0] d_reg   [STAGES];
    logic [N-1:0] d_next  [STAGES];
    logic         bo_next [STAGES];
    logic         en;

    assign en       = !ctl_reg[STAGES-1].valid || out_ready;
    assign in_ready = en;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = gi * CHUNK;
        localparam int W  = (gi == STAGES - 1) ? LAST_W : CHUNK;

        logic [W-1:0] diff_s;

        if (gi == 0) begin : g_head
            assign a_src[gi]   = a;
            assign b_src[gi]   = b;
            assign d_src[gi]   = '0;
            assign ctl_src[gi] = '{valid: in_valid, borrow: bin};
        end else begin : g_body
            assign a_src[gi]   = a_reg[gi-1];
            assign b_src[gi]   = b_reg[gi-1];
            assign d_src[gi]   = d_reg[gi-1];
            assign ctl_src[gi] = ctl_reg[gi-1];
        end

        rcs_chunk #(.W(W)) u_chunk (
            .x    (a_src[gi][LO +: W]),
            .y    (b_src[gi][LO +: W]),
            .bi   (ctl_src[gi].borrow),
            .diff (diff_s),
            .bo   (bo_next[gi])
        );

        // bits at and above LO are still zero in d_src, so OR merges the new slice
        assign d_next[gi] = d_src[gi] | (N'(diff_s) << LO);

        always_ff @(posedge clk) begin
            if (rst) begin
                ctl_reg[gi] <= '0;
                a_reg[gi]   <= '0;
                b_reg[gi]   <= '0;
                d_reg[gi]   <= '0;
            end else if (en) begin
                ctl_reg[gi] <= '{valid: ctl_src[gi].valid, borrow: bo_next[gi]};
                a_reg[gi]   <= a_src[gi];
                b_reg[gi]   <= b_src[gi];
                d_reg[gi]   <= d_next[gi];
            end
        end
    end

    assign out_valid = ctl_reg[STAGES-1].valid;
    assign d         = d_reg[STAGES-1];
    assign bout      = ctl_reg[STAGES-1].borrow;
    assign ovf       = (a_reg[STAGES-1][N-1] ^ b_reg[STAGES-1][N-1]) &
                       (d_reg[STAGES-1][N-1] ^ a_reg[STAGES-1][N-1]);

`ifdef SUB_CMP_EN
    logic eq_reg, lt_u_reg, lt_s_reg;
    logic ovf_fin;

    assign ovf_fin = (a_src[STAGES-1][N-1] ^ b_src[STAGES-1][N-1]) &
                     (d_next[STAGES-1][N-1] ^ a_src[STAGES-1][N-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_reg   <= 1'b0;
            lt_u_reg <= 1'b0;
            lt_s_reg <= 1'b0;
        end else if (en) begin
            eq_reg   <= (d_next[STAGES-1] == '0) && !bo_next[STAGES-1];
            lt_u_reg <= bo_next[STAGES-1];
            lt_s_reg <= d_next[STAGES-1][N-1] ^ ovf_fin;
        end
    end

    assign eq   = eq_reg;
    assign lt_u = lt_u_reg;
    assign lt_s = lt_s_reg;
`endif

endmodule

// File: tb/tb_rcs_pipe_sub.sv
// Directed table-driven bench for rcs_pipe_sub (N=34, CHUNK=8, five stages).
module tb_rcs_pipe_sub;

    localparam int N = 34;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] d;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t tbl [8];

    rcs_pipe_sub #(.N(N), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: {ovf, bout, d}
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic bi);
        logic [N:0] full;
        logic       v;
        full = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
        v    = (x[N-1] != y[N-1]) && (full[N-1] != x[N-1]);
        return {v, full[N], full[N-1:0]};
    endfunction

    // Single op into an empty pipe; checks latency and result fields.
    task automatic apply_vec(input int idx, input vec_t v);
        int lat;
        bit got;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = v.a; b = v.b; bin = v.bin;
        #1 chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        lat = 1;
        got = 0;
        while (!got && lat <= 20) begin
            #1;
            if (out_valid) got = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'd5);
        chk($sformatf("v%0d_d", idx), 64'(d), 64'(v.d));
        chk($sformatf("v%0d_bout", idx), 64'(bout), 64'(v.bout));
        chk($sformatf("v%0d_ovf", idx), 64'(ovf), 64'(v.ovf));
        $display("vec %0d: a=%0h b=%0h bin=%0d -> d=%0h bout=%0d ovf=%0d lat=%0d",
                 idx, v.a, v.b, v.bin, d, bout, ovf, lat);
    endtask

    initial begin
        logic [N-1:0] ra [10];
        logic [N-1:0] rb [10];
        logic         rbin [10];
        logic [N+1:0] expq [$];
        logic [N+1:0] e;
        logic [N-1:0] hold_d;
        bit           have_hold;
        int           sent, recv, n_stall, ghost;

        tbl[0] = '{34'h100,         34'h1,          1'b0, 34'h0FF,        1'b0, 1'b0};
        tbl[1] = '{34'h0,           34'h1,          1'b0, 34'h3_FFFF_FFFF, 1'b1, 1'b0};
        tbl[2] = '{34'h2_0000_0000, 34'h1,          1'b0, 34'h1_FFFF_FFFF, 1'b0, 1'b1};
        tbl[3] = '{34'h1_2345_6789, 34'h1_2345_6789, 1'b1, 34'h3_FFFF_FFFF, 1'b1, 1'b0};
        tbl[4] = '{34'h5,           34'h3,          1'b1, 34'h1,          1'b0, 1'b0};
        tbl[5] = '{34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 1'b0, 34'h0,          1'b0, 1'b0};
        tbl[6] = '{34'h1_FFFF_FFFF, 34'h3_FFFF_FFFF, 1'b0, 34'h2_0000_0000, 1'b1, 1'b1};
        tbl[7] = '{34'h0,           34'h0,          1'b1, 34'h3_FFFF_FFFF, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_d", 64'(d), 64'd0);
        chk("reset_bout", 64'(bout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) apply_vec(i, tbl[i]);

        // Back-to-back stream with out_ready low on cycles 3..6
        for (int i = 0; i < 10; i++) begin
            ra[i]   = N'({$urandom(), $urandom()});
            rb[i]   = N'({$urandom(), $urandom()});
            rbin[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; recv = 0; n_stall = 0; have_hold = 0;
        for (int c = 0; c < 80 && recv < 10; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 10) begin
                in_valid = 1'b1; a = ra[sent]; b = rb[sent]; bin = rbin[sent];
            end else begin
                in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                chk($sformatf("stall_c%0d_in_ready", c), 64'(in_ready), 64'd0);
                if (have_hold) chk($sformatf("stall_c%0d_d_hold", c), 64'(d), 64'(hold_d));
                hold_d = d; have_hold = 1; n_stall++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("stream_extra_output", 64'(d), 64'hDEAD);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("stream_r%0d", recv), 64'({ovf, bout, d}), 64'(e));
                    $display("stream %0d: d=%0h bout=%0d ovf=%0d exp=%0h", recv, d, bout, ovf, e[N-1:0]);
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(ra[sent], rb[sent], rbin[sent]));
                sent++;
            end
        end
        chk("stream_recv_count", 64'(recv), 64'd10);
        chk("stream_stall_cycles", 64'(n_stall), 64'd2);
        in_valid = 1'b0; out_ready = 1'b1;

        // Three items in flight, then a one-cycle reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; bin = tbl[i].bin;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_d", 64'(d), 64'd0);
        ghost = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1 if (out_valid) ghost++;
        end
        chk("midrst_no_ghost", 64'(ghost), 64'd0);
        $display("midrst: ghost outputs=%0d", ghost);
        apply_vec(8, tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
